r2r_sample_sequencer: RTL

- Sample source stage that sits directly upstream of the R2R DAC driver chain.
- Produces the 8-bit code that drives the eight 1v8→3v3 level shifters and the R2R ladder.
- Code comes either from host-written samples buffered in a FIFO or from a built-in test waveform.
- Output is paced by a programmable sample-rate divider.

---
 rtl/r2r_sample_sequencer_if.sv | 25 ++
 rtl/r2r_sample_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/r2r_sample_sequencer_if.sv
// Host-side bus of the R2R sample sequencer: sample/divider writes, mode select, DAC code and status.
// The master modport belongs to the host, the slave modport to the sequencer.
interface r2r_sample_sequencer_if;
   logic [7:0] data;
   logic       wr;
   logic       div_load;
   logic [1:0] mode;
   logic       clr_flags;
   logic [7:0] r2r_code;
   logic       sample_tick;
   logic       fifo_full;
   logic       fifo_empty;
   logic       overflow;
   logic       underrun;

   modport master (
      output data, wr, div_load, mode, clr_flags,
      input  r2r_code, sample_tick, fifo_full, fifo_empty, overflow, underrun
   );

   modport slave (
      input  data, wr, div_load, mode, clr_flags,
      output r2r_code, sample_tick, fifo_full, fifo_empty, overflow, underrun
   );
endinterface

// File: rtl/r2r_sample_sequencer.sv
// Paced DAC code source: FIFO playback or saw/triangle/square waveform, one step per divider tick.
// r2r_code updates on the edge ending a tick cycle; FIFO writes never stall, excess writes are dropped and flagged.
module r2r_sample_sequencer #(
   parameter int DEPTH     = 8,
   parameter int DIV_RESET = 9
) (
   input logic                   clk,
   input logic                   rst,
   r2r_sample_sequencer_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [7:0] DIV_INIT = 8'(DIV_RESET);
   localparam logic [1:0] M_FIFO   = 2'b00;
   localparam logic [1:0] M_SAW    = 2'b01;
   localparam logic [1:0] M_TRI    = 2'b10;
   localparam logic [1:0] M_SQR    = 2'b11;

   logic [7:0]    div_reg, cnt, code, code_next;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [1:0]    mode_q;
   logic          dir, dir_eff, dir_next;
   logic          tick, empty, full, wr_eff, pop, push;
   logic          ovf_set, und_set, overflow_q, underrun_q;

   assign tick    = (cnt == 8'd0);
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   // div_load owns the data bus that cycle, so a coincident write is discarded
   assign wr_eff  = bus.wr & ~bus.div_load;
   assign pop     = tick & (bus.mode == M_FIFO) & ~empty;
   assign push    = wr_eff & (~full | pop);
   assign ovf_set = wr_eff & full & ~pop;
   assign und_set = tick & (bus.mode == M_FIFO) & empty;

   // Entering triangle picks the direction that can still move from the current code
   assign dir_eff = ((bus.mode == M_TRI) && (mode_q != M_TRI)) ? (code != 8'hFF) : dir;

   always_comb begin
      code_next = code;
      dir_next  = dir_eff;
      if (tick) begin
         unique case (bus.mode)
            M_FIFO: if (pop) code_next = mem[rd_ptr];
            M_SAW:  code_next = code + 8'd1;
            M_TRI: begin
               if (dir_eff) begin
                  code_next = code + 8'd1;
                  if (code == 8'hFE) dir_next = 1'b0;
               end else begin
                  code_next = code - 8'd1;
                  if (code == 8'h01) dir_next = 1'b1;
               end
            end
            M_SQR:  code_next = code[7] ? 8'h00 : 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg <= DIV_INIT;
         cnt     <= DIV_INIT;
      end else if (bus.div_load) begin
         div_reg <= bus.data;
         cnt     <= bus.data;
      end else if (tick) begin
         cnt <= div_reg;
      end else begin
         cnt <= cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code       <= 8'h00;
         dir        <= 1'b1;
         mode_q     <= M_FIFO;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         code       <= code_next;
         dir        <= dir_next;
         mode_q     <= bus.mode;
         overflow_q <= ovf_set | (overflow_q & ~bus.clr_flags);
         underrun_q <= und_set | (underrun_q & ~bus.clr_flags);
      end
   end

   assign bus.r2r_code    = code;
   assign bus.sample_tick = tick;
   assign bus.fifo_full   = full;
   assign bus.fifo_empty  = empty;
   assign bus.overflow    = overflow_q;
   assign bus.underrun    = underrun_q;
endmodule
